// File: rtl/muldiv_unit_pkg.sv
// Shared types and op-class helpers for the iterative multiply/divide unit.
// Optional early-out path is enabled by MULDIV_EARLY_OUT_EN.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MUL,
    MD_MULH,
    MD_MULHU,
    MD_DIV,
    MD_DIVU,
    MD_MOD,
    MD_MODU
  } muldiv_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } muldiv_state_e;

  function automatic logic op_is_mul(input logic [2:0] op);
    return op inside {MD_MUL, MD_MULH, MD_MULHU};
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return op inside {MD_DIV, MD_DIVU, MD_MOD, MD_MODU};
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return op inside {MD_MULH, MD_DIV, MD_MOD};
  endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// Combinational BITS_PER_CYCLE iterations of shift-add multiply
// or restoring divide over the shared {hi, lo} shift register.
module muldiv_unit_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             is_mul,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n,
  output logic [WIDTH-1:0] b_n
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     r_ext;
  logic [WIDTH-1:0]   h, l, m;

  always_comb begin
    h     = hi;
    l     = lo;
    m     = b;
    acc   = '0;
    r_ext = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_mul) begin
        // MSB-first: shift accumulator, add multiplicand per multiplier bit
        acc = {h, l} << 1;
        if (m[WIDTH-1])
          acc = acc + {{WIDTH{1'b0}}, a};
        {h, l} = acc;
        m = m << 1;
      end else begin
        r_ext = {h, l[WIDTH-1]};
        l = l << 1;
        if (r_ext >= {1'b0, b}) begin
          r_ext = r_ext - {1'b0, b};
          l[0]  = 1'b1;
        end
        h = r_ext[WIDTH-1:0];
      end
    end
    hi_n = h;
    lo_n = l;
    b_n  = m;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MUL/MULH/MULHU/DIV/DIVU/MOD/MODU unit with valid/ready and flush.
// Define MULDIV_EARLY_OUT_EN to short-cut trivial operands past CALC.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  muldiv_state_e    state;
  logic [2:0]       op;
  logic [TAG_W-1:0] tag;
  logic [WIDTH-1:0] a, b, hi, lo;
  logic             neg_q, neg_r;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] hi_n, lo_n, b_n;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] mulh, q_fix, r_fix, fix_result;
  logic             sa, sb, is_mul;

  assign in_ready  = state == S_IDLE;
  assign busy      = state != S_IDLE;
  assign out_valid = state == S_DONE;

  assign is_mul = op_is_mul(op);
  assign sa     = op_is_signed(op) & a[WIDTH-1];
  assign sb     = op_is_signed(op) & b[WIDTH-1];
  assign a_abs  = sa ? -a : a;
  assign b_abs  = sb ? -b : b;

  // high half of -{hi,lo}: carry into hi only when lo is zero
  assign mulh  = neg_q ? ~hi + WIDTH'(lo == '0) : hi;
  assign q_fix = neg_q ? -lo : lo;
  assign r_fix = neg_r ? -hi : hi;

  always_comb begin
    fix_result = '0;
    unique case (op)
      MD_MUL:          fix_result = lo;
      MD_MULH:         fix_result = mulh;
      MD_MULHU:        fix_result = hi;
      MD_DIV, MD_DIVU: fix_result = q_fix;
      MD_MOD, MD_MODU: fix_result = r_fix;
      default:         fix_result = '0;
    endcase
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic div_zero, eo_hit;

  assign div_zero = b == '0;

  always_comb begin
    eo_hit = 1'b0;
    unique case (1'b1)
      is_mul:        eo_hit = (a == '0) | div_zero;
      op_is_div(op): eo_hit = div_zero | (a_abs < b_abs);
      default:       eo_hit = 1'b0;
    endcase
  end
`endif

  muldiv_unit_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .is_mul (is_mul),
    .hi     (hi),
    .lo     (lo),
    .a      (a),
    .b      (b),
    .hi_n   (hi_n),
    .lo_n   (lo_n),
    .b_n    (b_n)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op         <= '0;
      tag        <= '0;
      a          <= '0;
      b          <= '0;
      hi         <= '0;
      lo         <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      cnt        <= '0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            op    <= in_op;
            tag   <= in_tag;
            a     <= in_src1;
            b     <= in_src2;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          a     <= a_abs;
          b     <= b_abs;
          hi    <= '0;
          lo    <= is_mul ? '0 : a_abs;
          neg_q <= (sa ^ sb) & (is_mul | (b != '0));
          neg_r <= sa;
          cnt   <= CW'(N - 1);
          state <= S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
          // preload the final {rem, quo} so FIX produces the answer
          if (eo_hit) begin
            hi    <= is_mul ? '0 : a_abs;
            lo    <= (!is_mul && div_zero) ? '1 : '0;
            state <= S_FIX;
          end
`endif
        end
        S_CALC: begin
          hi  <= hi_n;
          lo  <= lo_n;
          b   <= b_n;
          cnt <= cnt - 1'b1;
          if (cnt == '0)
            state <= S_FIX;
        end
        S_FIX: begin
          out_result <= fix_result;
          out_tag    <= tag;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + random bench for muldiv_unit (WIDTH=32, one bit per cycle)
// against an arithmetic reference model and a per-cycle output monitor.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;
  localparam int N = 32;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]    in_op;
  logic [W-1:0]  in_src1, in_src2, out_result;
  logic [4:0]    in_tag, out_tag;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          acc;
    int          lat;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] e;
  } vec_t;
  vec_t vecs [20];

  muldiv_unit dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy, p;
    longint unsigned ux, uy;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (op)
      MD_MUL:   begin p = sx * sy; return 32'(p); end
      MD_MULH:  begin p = sx * sy; return 32'(p >>> 32); end
      MD_MULHU: return 32'((ux * uy) >> 32);
      MD_DIV:   return (y == 0) ? 32'hFFFFFFFF : 32'(sx / sy);
      MD_MOD:   return (y == 0) ? x : 32'(sx % sy);
      MD_DIVU:  return (y == 0) ? 32'hFFFFFFFF : 32'(ux / uy);
      MD_MODU:  return (y == 0) ? x : 32'(ux % uy);
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
    longint mx, my;
    bit sg;
    sg = (op == MD_DIV) || (op == MD_MOD);
    mx = sg ? longint'(signed'(x)) : longint'({32'd0, x});
    my = sg ? longint'(signed'(y)) : longint'({32'd0, y});
    if (mx < 0) mx = -mx;
    if (my < 0) my = -my;
    if (op <= MD_MULHU && (x == 0 || y == 0)) return 2;
    if (op >= MD_DIV && op <= MD_MODU && (y == 0 || mx < my)) return 2;
`endif
    return N + 2;
  endfunction

  task automatic monitor();
    bit seen = 0;
    bit chk_idle = 0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        seen = 0;
        chk_idle = 0;
      end else begin
        if (chk_idle) begin
          chk("idle_after_handshake", {30'd0, busy, in_ready}, 32'd1);
          chk_idle = 0;
        end
        if (!out_valid) begin
          seen = 0;
        end else if (q.size() == 0) begin
          chk("spurious_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          if (!seen) chk("latency", cyc - q[0].acc, q[0].lat);
          seen = 1;
          chk("result", out_result, q[0].res);
          chk("tag", {27'd0, out_tag}, {27'd0, q[0].tag});
          chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
          if (out_ready && !flush) begin
            void'(q.pop_front());
            seen = 0;
            chk_idle = 1;
          end
        end
      end
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] t,
                       input logic [31:0] e);
    int n = 0;
    exp_t it;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = x;
    in_src2  = y;
    in_tag   = t;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    it.res = e;
    it.tag = t;
    it.acc = cyc + 1;
    it.lat = exp_lat(op, x, y);
    q.push_back(it);
    @(negedge clk);
    in_valid = 1'b0;
    in_src1  = ~x;
    in_src2  = ~y;
    in_tag   = ~t;
  endtask

  task automatic wait_done(input bit rnd);
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    out_ready = 1'b1;
    chk("done_timeout", q.size(), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [2:0]  op;
    logic [31:0] x, y;

    vecs = '{
      '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD},
      '{MD_MOD,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF},
      '{MD_MODU,  32'd7,        32'd2,        32'd1},
      '{MD_DIVU,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF},
      '{MD_MULH,  32'h80000000, 32'h80000000, 32'h40000000},
      '{MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
      '{MD_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},
      '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000},
      '{MD_MOD,   32'h80000000, 32'hFFFFFFFF, 32'h00000000},
      '{MD_DIV,   32'h12345678, 32'd0,        32'hFFFFFFFF},
      '{MD_MOD,   32'h12345678, 32'd0,        32'h12345678},
      '{MD_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF},
      '{MD_MODU,  32'd5,        32'd0,        32'd5},
      '{MD_MOD,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9},
      '{MD_MUL,   32'd0,        32'h1234,     32'd0},
      '{MD_DIV,   32'd3,        32'd7,        32'd0},
      '{MD_MOD,   32'hFFFFFFFD, 32'd7,        32'hFFFFFFFD},
      '{MD_MULH,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF},
      '{MD_MUL,   32'h12345678, 32'd16,       32'h23456780},
      '{3'd7,     32'd5,        32'd3,        32'd0}
    };

    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_src1   = '0;
    in_src2   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_out_result", out_result, 32'd0);
    chk("reset_out_tag", {27'd0, out_tag}, 32'd0);
    reset = 1'b0;
    fork
      monitor();
    join_none

    foreach (vecs[i]) begin
      chk("model_pin", model(vecs[i].op, vecs[i].x, vecs[i].y), vecs[i].e);
      issue(vecs[i].op, vecs[i].x, vecs[i].y, 5'(i + 1), vecs[i].e);
      wait_done(1'b0);
    end

    // consumer back-pressure: result and tag must hold while stalled
    out_ready = 1'b0;
    issue(MD_DIVU, 32'd100, 32'd7, 5'd21, 32'd14);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid_seen", {31'd0, out_valid}, 32'd1);
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    wait_done(1'b0);

    // flush in CALC cycle 10
    issue(MD_MUL, 32'd1234, 32'd5678, 5'd9, 32'd7006652);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    q.delete();
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (N + 5) @(negedge clk);
    issue(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, 32'hFFFFFFFE);
    wait_done(1'b0);

    // flush in IDLE blocks the accept
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = MD_DIV;
    in_src1  = 32'd50;
    in_src2  = 32'd3;
    flush    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    chk("flush_idle_busy", {31'd0, busy}, 32'd0);
    repeat (N + 5) @(negedge clk);

    // reset mid-operation clears registered outputs
    issue(MD_DIV, 32'd1000, 32'd3, 5'd30, 32'd333);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    #1;
    chk("rst_mid_flags", {29'd0, out_valid, busy, in_ready}, 32'd1);
    chk("rst_mid_result", out_result, 32'd0);
    chk("rst_mid_tag", {27'd0, out_tag}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = pick();
      y  = pick();
      issue(op, x, y, 5'(i), model(op, x, y));
      wait_done(1'b1);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
